// File: rtl/wallace_pipelined_mult.sv
// Signed 33x33 multiplier: operand register, Wallace-tree carry-save reduction, then a final
// carry-propagate add. The 65-bit product wraps modulo 2^65 and has a latency of two edges.
module wallace_pipelined_mult (
  output logic [64:0] c,
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        clk,
  input  logic        rst
);

  localparam int unsigned NumRows   = 34;
  localparam int unsigned NumLevels = 8;

  logic [32:0] a_q, b_q;
  logic [64:0] bext;
  logic [64:0] pp   [NumRows];
  logic [64:0] rows [NumRows];
  logic [64:0] nxt  [NumRows];
  logic [64:0] sum_d, carry_d;
  logic [64:0] sum_q, carry_q;
  logic [64:0] c_q;

  // Rows 0..31 add b weighted by a[i]. Bit 32 of a has negative weight, so its row is
  // ~(b<<32) plus a separate +1 row (pp[33]); together they give -(b<<32).
  always_comb begin
    bext = {{32{b_q[32]}}, b_q};
    for (int i = 0; i < 32; i++) begin
      pp[i] = a_q[i] ? (bext << i) : '0;
    end
    pp[32] = a_q[32] ? ~(bext << 32) : '0;
    pp[33] = {64'd0, a_q[32]};
  end

  // Each level applies 3:2 compressors to groups of three rows and passes leftover rows
  // through. The row counts per level are 34, 23, 16, 11, 8, 6, 4, 3, 2.
  always_comb begin
    int n;
    int m;
    int base;
    rows = pp;
    nxt  = '{default: '0};
    n    = NumRows;
    for (int l = 0; l < NumLevels; l++) begin
      nxt = '{default: '0};
      m   = 0;
      for (int g = 0; g < NumRows / 3; g++) begin
        if (3 * g + 2 < n) begin
          nxt[m]     = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
          nxt[m + 1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                        (rows[3*g+1] & rows[3*g+2])) << 1;
          m = m + 2;
        end
      end
      base = 3 * (n / 3);
      for (int k = 0; k < 2; k++) begin
        if (base + k < n) begin
          nxt[m] = rows[base + k];
          m = m + 1;
        end
      end
      rows = nxt;
      n    = m;
    end
    sum_d   = rows[0];
    carry_d = rows[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      c_q     <= '0;
    end else begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_q     <= sum_q + carry_q;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_wallace_pipelined_mult.sv
// Scoreboard bench for wallace_pipelined_mult. Stimulus queues the expected products, and a
// negedge monitor checks each one in the cycle it is due.
module tb_wallace_pipelined_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [32:0] a = '0;
  logic [32:0] b = '0;
  logic [64:0] c;

  typedef struct {
    logic [64:0] exp;
    int          due;
    string       name;
  } item_t;

  item_t q[$];
  int    cyc        = 0;
  int    zero_until = -1;
  int    total      = 0;
  int    bad        = 0;

  wallace_pipelined_mult dut (
    .c   (c),
    .a   (a),
    .b   (b),
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Reference product: sign-extend both operands to 66 bits, multiply, keep the low 65 bits.
  function automatic logic [64:0] model(input logic [32:0] x, input logic [32:0] y);
    logic signed [65:0] xe, ye, p;
    xe = $signed({{33{x[32]}}, x});
    ye = $signed({{33{y[32]}}, y});
    p  = xe * ye;
    return p[64:0];
  endfunction

  function automatic logic [32:0] rnd33();
    logic [32:0] v;
    case ($urandom_range(0, 7))
      0:       v = 33'h1_0000_0000;
      1:       v = 33'h0_ffff_ffff;
      2:       v = '1;
      3:       v = '0;
      4:       v = {28'd0, 5'($urandom_range(0, 31))};
      default: v = {1'($urandom_range(0, 1)), 32'($urandom)};
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic put(input logic [32:0] x, input logic [32:0] y, input logic [64:0] want,
                     input string name);
    item_t it;
    a       = x;
    b       = y;
    it.exp  = want;
    it.due  = cyc + 3;
    it.name = name;
    q.push_back(it);
  endtask

  task automatic drive(input logic [32:0] x, input logic [32:0] y, input logic [64:0] want,
                       input string name);
    @(negedge clk);
    put(x, y, want, name);
  endtask

  // Monitor: c must be zero in reset and during the refill window; otherwise it must match
  // the queued product that is due in this cycle.
  always @(negedge clk) begin
    item_t it;
    if (!rst) begin
      check("reset_zero", c, 65'd0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      it = q.pop_front();
      check(it.name, c, it.exp);
    end else if (cyc <= zero_until) begin
      check("post_release_zero", c, 65'd0);
    end else if (q.size() > 0 && q[0].due < cyc) begin
      it = q.pop_front();
      check({it.name, "_missed"}, c, it.exp);
    end
  end

  initial begin
    logic [32:0] x, y;
    a = 33'd19;
    b = 33'd15;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    zero_until = cyc + 2;
    put(33'd19, 33'd15, 65'd285, "reset_release_285");

    drive(33'd5, 33'd10, 65'd50, "small_50");
    drive(33'd9943000, 33'd3302367, 65'd32835435081000, "large_pos");
    drive(-33'sd7, 33'sd6, -65'sd42, "neg_pos");
    drive(-33'sd7, -33'sd6, 65'sd42, "neg_neg");
    drive(33'd0, -33'sd1, 65'd0, "zero_negone");
    drive(33'd4294967295, 33'd4294967295, 65'd18446744065119617025, "max_max");
    drive(33'h1_0000_0000, 33'd4294967295, -65'sd18446744069414584320, "min_max");
    drive(33'h1_0000_0000, 33'h1_0000_0000, 65'h1_0000_0000_0000_0000, "min_min_wrap");

    for (int i = 0; i < 200; i++) begin
      x = rnd33();
      y = rnd33();
      drive(x, y, model(x, y), "random");
    end

    // Reset between edges while results are still in flight.
    drive(33'd3, 33'd7, 65'd21, "midstream_0");
    drive(33'd11, 33'd13, 65'd143, "midstream_1");
    drive(-33'sd9, 33'd4, -65'sd36, "midstream_2");
    drive(33'd100, 33'd100, 65'd10000, "midstream_3");
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("async_clear", c, 65'd0);
    q.delete();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    zero_until = cyc + 2;
    put(33'd17, 33'd23, 65'd391, "post_release_first");
    for (int i = 0; i < 20; i++) begin
      x = rnd33();
      y = rnd33();
      drive(x, y, model(x, y), "post_release_random");
    end

    repeat (5) @(negedge clk);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain_empty: got=%0d pending want=0 pending", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wallace_pipelined_mult.md
Name: wallace_pipelined_mult

Overview:
- Pipelined signed 33x33-bit Wallace-tree multiplier producing a 65-bit two's-complement product.
- Datapath arithmetic block, one new operand pair accepted every clock cycle, fixed latency.
- No handshake: upstream drives operands every cycle; downstream samples the product a fixed number of cycles later.

Parameters:
- None. Widths are fixed at 33-bit operands and a 65-bit product.

Ports:
- clk  input  1   rising-edge clock
- rst  input  1   asynchronous active-low reset (0 = reset)
- c    output 65  signed product a*b, registered
- a    input  33  signed multiplier operand (two's complement)
- b    input  33  signed multiplicand operand (two's complement)
- Instantiation port order: c, a, b, clk, rst.

Behaviour:
- Reset: rst low immediately clears every pipeline register, asynchronously. c = 0 while rst is low. On rst deassertion, c stays 0 until valid data propagates.
- Pipeline has 3 register stages:
  - S1 (edge k): register a and b.
  - S2 (edge k+1): generate 33 signed partial products (Baugh-Wooley or sign-extended rows). Reduce them with a Wallace tree of full/half adders (3:2 and 2:2 compressors) to two rows (sum, carry). Register both rows.
  - S3 (edge k+2): final carry-propagate add of sum + carry, registered into c.
- Latency: operands stable at rising edge k appear on c immediately after rising edge k+2.
- Throughput: 1 result per cycle. Operands change every cycle without stalls or bubbles.
- Arithmetic:
  - c equals the exact two's-complement product for all operand pairs except a = b = -2^32.
  - For a = b = -2^32 the exact value 2^64 needs 66 bits; c is the low 65 bits, i.e. -2^64. Overflow is wrapped, not saturated, and not flagged.
- Reset mid-operation: all in-flight results are discarded. After release, the first nonzero c is the product of operands sampled at the first rising edge with rst high, appearing 2 edges later.
- No X propagation. c is a pure registered output with no combinational path from a/b.

Test Plan:
- Reset: hold rst=0 for 2 cycles with a=19, b=15 -> c=0 throughout. Release rst -> c=285 after the 3rd register stage.
- Small positives: a=19, b=15, then a=5, b=10 on consecutive cycles -> c=285 then c=50 on consecutive cycles at latency 3.
- Large positive: a=9943000, b=3302367 -> c=32835435081000.
- Signs:
  - a=-7, b=6 -> c=-42
  - a=-7, b=-6 -> c=42
  - a=0, b=-1 -> c=0
- Extremes:
  - a=b=4294967295 -> c=18446744065119617025
  - a=-4294967296, b=4294967295 -> c=-18446744069414584320
  - a=b=-4294967296 -> c=-18446744073709551616 (wrapped)
- Reset mid-stream: stream 4 operand pairs, assert rst between edges -> c goes to 0 immediately. Release -> only post-release products appear, in order, at latency 3.
